dff_stim_sequencer: RTL and testbench
=====================================

# dff_stim_sequencer

Controller that exercises a player-built D flip-flop in the logic game: it plays a latched D pattern into the flop one bit per step, issues a single-cycle capture enable, then checks Q and notQ against the driven bit. It sits between the level logic, which supplies the pattern and `start`, and the player's flop, which it drives and observes. The result is a pass flag and a mismatch count for the level scoreboard.

## Interface
Parameters:
- `PATTERN_LEN`, default 8: number of steps (bits) per run, range 1–32.
- `SETUP_CYCLES`, default 4: cycles that `d_out` is held stable before the capture strobe, range ≥1.

Ports:
- `clk` input, 1 bit: single system clock. All logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: begin a run. Sampled only in IDLE.
- `pattern` input, PATTERN_LEN bits: D bits to play. Bit 0 is played first. Latched at start.
- `q_in` input, 1 bit: Q from the flop under test.
- `notq_in` input, 1 bit: notQ from the flop under test.
- `d_out` output, 1 bit: D driven to the flop under test.
- `dut_en` output, 1 bit: one-cycle capture enable to the flop under test.
- `busy` output, 1 bit: high from SETUP through CHECK.
- `done` output, 1 bit: one-cycle pulse at the end of a run.
- `pass` output, 1 bit: run result. Valid when `done` pulses, held until the next start.
- `err_count` output, $clog2(PATTERN_LEN+1) bits: mismatching steps in the current or last run.
- `step_idx` output, $clog2(PATTERN_LEN) bits (minimum 1): index of the current step.

## Operation
- FSM states: IDLE, SETUP, STROBE, SETTLE, CHECK, DONE.
- IDLE, when `start` is high:
  - latch `pattern`;
  - clear `err_count`, `step_idx` and `pass`;
  - go to SETUP.
- SETUP: `d_out` = latched bit[`step_idx`]. Hold for SETUP_CYCLES cycles, then go to STROBE.
- STROBE: `dut_en` = 1 for exactly this cycle. `d_out` is unchanged. Go to SETTLE.
- SETTLE: one cycle so the flop output can register. Go to CHECK.
- CHECK: a step mismatches if `q_in` != `d_out`, or if `notq_in` != ~`q_in`.
  - On a mismatch, increment `err_count`.
  - If `step_idx` == PATTERN_LEN-1, go to DONE.
  - Otherwise increment `step_idx` and go to SETUP.
- DONE:
  - `done` = 1 for one cycle;
  - `pass` = (final `err_count` == 0);
  - go to IDLE.
- `start` is ignored in any state other than IDLE. Changes to `pattern` after the latch are ignored.
- `err_count` saturates at all-ones. It cannot exceed PATTERN_LEN by construction.
- In IDLE, `d_out` holds the last driven bit, so the flop under test does not glitch.

## Timing
- Reset values, applied in the cycle after `rst` is sampled high:
  - state = IDLE;
  - `d_out`, `dut_en`, `busy`, `done`, `pass` all 0;
  - `err_count` = 0, `step_idx` = 0.
- `rst` mid-run aborts immediately. No `done` pulse is produced and `pass` = 0.
- `start` sampled at edge k:
  - SETUP is entered at k+1;
  - `busy` = 1 and `d_out` is valid from k+1.
- Step length is SETUP_CYCLES + 3 cycles. With defaults: 7 cycles per step, 56 cycles per run.
- `done` is asserted PATTERN_LEN × (SETUP_CYCLES+3) + 1 cycles after the start edge.
- `busy` falls in the same cycle that `done` rises.
- `q_in` and `notq_in` are sampled only in CHECK, which is 2 cycles after `dut_en`.
- `rst` and `start` high in the same cycle: `rst` wins.
- `start` in the DONE cycle is ignored. `start` in the cycle after DONE is accepted.

## Configuration
- Macro: `DFF_STIM_SEQUENCER_EARLY_ABORT_EN`.
- When defined, the first mismatch in CHECK goes straight to DONE:
  - `pass` = 0, `err_count` = 1;
  - remaining steps are skipped;
  - `step_idx` holds the failing index.
- When undefined, all PATTERN_LEN steps always run, and `err_count` reports the total number of mismatches.

## Structure
- Package `dff_stim_pkg` holds:
  - the FSM state enum `dff_stim_state_t`;
  - localparam helpers for the `err_count` and `step_idx` widths.
- One sub-module, `dff_stim_timer`: a loadable down-counter for the SETUP hold, with load and expire pulses.
- Everything else lives in the top-level FSM.

## Test plan
- **Ideal flop, defaults:** model a correct enabled D flip-flop; `pattern` = 8'b1011_0010, pulse `start`.
  - `done` at cycle 57; `pass` = 1; `err_count` = 0.
  - Bits are played LSB first, and `dut_en` pulses 8 times, each one 4 cycles after its SETUP begins.
- **Stuck-at-0 Q:** tie `q_in` to 0 and `notq_in` to 1; `pattern` = 8'hA5.
  - `pass` = 0; `err_count` = 4.
- **Broken notQ:** correct Q, but `notq_in` = `q_in`; `pattern` = 8'h0F.
  - `err_count` = 8; `pass` = 0.
- **Reset mid-run:** assert `rst` for 1 cycle during step 3.
  - Next cycle: all outputs are at reset values and no `done` pulse occurs.
  - A fresh `start` then completes normally.
- **Start while busy:** pulse `start` again at cycle 20 with a different `pattern`.
  - Ignored: the run completes with the original pattern and the same `done` timing.
- **Early abort (macro defined):** stuck-at-0 Q, `pattern` = 8'b0000_0100.
  - `done` after step 2's CHECK; `err_count` = 1; `step_idx` = 2; `pass` = 0.

Source files
------------

// File: rtl/dff_stim_pkg.sv
// Shared types and width helpers for the D flip-flop stimulus sequencer.
//   dff_stim_state_t : sequencer FSM states
//   err_width()      : width of a mismatch counter able to hold 0..len
//   idx_width()      : width of a step index for len steps (minimum 1)
package dff_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } dff_stim_state_t;

  localparam int unsigned DEFAULT_PATTERN_LEN  = 8;
  localparam int unsigned DEFAULT_SETUP_CYCLES = 4;

  function automatic int unsigned err_width(input int unsigned len);
    return $clog2(len + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned len);
    return (len < 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/dff_stim_timer.sv
// Loadable down-counter that times the SETUP hold.
//   clk, rst  : clock, synchronous active-high reset
//   load      : pulse, (re)starts the count from load_val
//   load_val  : number of cycles minus one to hold
//   expire_c  : combinational pulse in the last cycle of the hold
module dff_stim_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire_c
);

  logic [W-1:0] count;
  logic         running;

  assign expire_c = running && (count == '0);

  // Count down once per cycle after a load; expire fires exactly once.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      running <= 1'b0;
    end else if (load) begin
      count   <= load_val;
      running <= 1'b1;
    end else if (running) begin
      if (count == '0) running <= 1'b0;
      else             count   <= count - W'(1);
    end
  end

endmodule

// File: rtl/dff_stim_sequencer.sv
// Stimulus sequencer for a player-built D flip-flop: plays a latched pattern
// LSB first, strobes the flop's enable once per step, and checks Q / notQ.
//   clk, rst          : clock, synchronous active-high reset
//   start, pattern    : begin a run with this D pattern (sampled in IDLE)
//   q_in, notq_in     : outputs of the flop under test
//   d_out, dut_en     : D and one-cycle capture enable to the flop
//   busy, done, pass  : run status; pass valid from the done pulse
//   err_count         : mismatching steps in the current / last run
//   step_idx          : index of the current step
// Optional: define DFF_STIM_SEQUENCER_EARLY_ABORT_EN to end a run at the
// first mismatching step.
module dff_stim_sequencer
  import dff_stim_pkg::*;
#(
  parameter  int unsigned PATTERN_LEN  = DEFAULT_PATTERN_LEN,
  parameter  int unsigned SETUP_CYCLES = DEFAULT_SETUP_CYCLES,
  localparam int unsigned ERR_W        = err_width(PATTERN_LEN),
  localparam int unsigned IDX_W        = idx_width(PATTERN_LEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PATTERN_LEN-1:0] pattern,
  input  logic                   q_in,
  input  logic                   notq_in,
  output logic                   d_out,
  output logic                   dut_en,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_W-1:0]       err_count,
  output logic [IDX_W-1:0]       step_idx
);

  localparam int unsigned      TMR_W    = (SETUP_CYCLES < 2) ? 1 : $clog2(SETUP_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SETUP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PATTERN_LEN - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  dff_stim_state_t        state;
  logic [PATTERN_LEN-1:0] pattern_q;      // remaining bits, current step at [0]
  logic [PATTERN_LEN-1:0] pattern_next_c;
  logic                   mismatch_c;
  logic                   last_step_c;
  logic                   abort_c;
  logic                   enter_setup_c;
  logic                   tmr_expire_c;

  assign pattern_next_c = pattern_q >> 1;
  assign mismatch_c     = (q_in != d_out) || (notq_in != ~q_in);
  assign last_step_c    = (step_idx == LAST_IDX);

`ifdef DFF_STIM_SEQUENCER_EARLY_ABORT_EN
  assign abort_c = mismatch_c;
`else
  assign abort_c = 1'b0;
`endif

  // Timer is (re)loaded on every transition into SETUP.
  assign enter_setup_c = ((state == ST_IDLE) && start) ||
                         ((state == ST_CHECK) && !last_step_c && !abort_c);

  dff_stim_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (enter_setup_c),
    .load_val (TMR_LOAD),
    .expire_c (tmr_expire_c)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pattern_q <= '0;
      d_out     <= 1'b0;
      dut_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      step_idx  <= '0;
    end else begin
      dut_en <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        // d_out keeps its last value here so the flop input never glitches.
        ST_IDLE: begin
          if (start) begin
            pattern_q <= pattern;
            d_out     <= pattern[0];
            err_count <= '0;
            step_idx  <= '0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_expire_c) begin
            dut_en <= 1'b1;
            state  <= ST_STROBE;
          end
        end
        ST_STROBE: state <= ST_SETTLE;
        ST_SETTLE: state <= ST_CHECK;
        ST_CHECK: begin
          if (mismatch_c && (err_count != ERR_MAX)) begin
            err_count <= err_count + ERR_W'(1);
          end
          if (last_step_c || abort_c) begin
            state <= ST_DONE;
          end else begin
            step_idx  <= step_idx + IDX_W'(1);
            pattern_q <= pattern_next_c;
            d_out     <= pattern_next_c[0];
            state     <= ST_SETUP;
          end
        end
        // busy drops together with the done pulse.
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_count == '0);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_stim_sequencer.sv
// Self-checking bench for dff_stim_sequencer with default parameters.
// A behavioural flop model drives q_in / notq_in with optional faults.
module tb_dff_stim_sequencer;

  localparam int L      = 8;
  localparam int S      = 4;
  localparam int STEP   = S + 3;
  localparam int EW     = 4;
  localparam int IW     = 3;
  localparam int BUDGET = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [L-1:0]  pattern = '0;
  logic          q_in, notq_in;
  logic          d_out, dut_en, busy, done, pass;
  logic [EW-1:0] err_count;
  logic [IW-1:0] step_idx;

  int n_tests = 0;
  int n_fail  = 0;

  // 0: ideal flop, 1: Q stuck at 0, 2: notQ follows Q
  int   fault_mode = 0;
  logic flop_q = 1'b0;
  int   en_cyc [L];
  logic en_bit [L];

  always #5 clk = ~clk;

  always @(posedge clk) if (dut_en) flop_q <= d_out;

  always_comb begin
    q_in    = (fault_mode == 1) ? 1'b0 : flop_q;
    notq_in = (fault_mode == 2) ? q_in : ~q_in;
  end

  dff_stim_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .q_in      (q_in),
    .notq_in   (notq_in),
    .d_out     (d_out),
    .dut_en    (dut_en),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .step_idx  (step_idx)
  );

  // Expected outcome of one run from the per-bit mismatch rule.
  task automatic model(input logic [L-1:0] pat, input int fm,
                       output int exp_done, output logic exp_pass,
                       output int exp_err, output int exp_idx, output int exp_steps);
    int first = -1;
    int cnt = 0;
    for (int j = 0; j < L; j++) begin
      bit mm;
      mm = (fm == 1) ? pat[j] : (fm == 2);
      if (mm) begin
        cnt++;
        if (first < 0) first = j;
      end
    end
`ifdef DFF_STIM_SEQUENCER_EARLY_ABORT_EN
    if (first >= 0) begin
      exp_steps = first + 1; exp_err = 1; exp_idx = first;
    end else begin
      exp_steps = L; exp_err = 0; exp_idx = L - 1;
    end
`else
    exp_steps = L; exp_err = cnt; exp_idx = L - 1;
`endif
    exp_done = exp_steps * STEP + 1;
    exp_pass = (exp_err == 0);
  endtask

  // Start a run and observe it until done or the cycle budget runs out.
  // Cycle c is sampled 1 time unit after the c-th edge following the start edge.
  task automatic do_run(input logic [L-1:0] pat, input int fm,
                        input int restart_cyc, input logic [L-1:0] alt_pat,
                        output int done_cyc, output logic pass_o,
                        output int err_o, output int idx_o,
                        output int en_n, output logic busy_at1);
    fault_mode = fm;
    done_cyc = -1; pass_o = 1'bx; err_o = -1; idx_o = -1; en_n = 0; busy_at1 = 1'b0;
    @(negedge clk);
    pattern = pat;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    pattern = L'($urandom);
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clk); #1;
      if (c == 1) busy_at1 = busy;
      if (start) start = 1'b0;
      if (dut_en) begin
        if (en_n < L) begin
          en_cyc[en_n] = c;
          en_bit[en_n] = d_out;
        end
        en_n++;
      end
      if (done) begin
        done_cyc = c;
        pass_o   = pass;
        err_o    = int'(err_count);
        idx_o    = int'(step_idx);
        if (busy !== 1'b0) begin
          n_tests++; n_fail++;
          $display("FAIL busy_at_done: busy=%b required 0", busy);
        end
        break;
      end
      if (c + 1 == restart_cyc) begin
        start   = 1'b1;
        pattern = alt_pat;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if ({d_out, dut_en, busy, done, pass} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: {d,en,busy,done,pass}=%b required 00000",
                         {d_out, dut_en, busy, done, pass});
    end
    n_tests++; if (err_count !== '0) begin
      n_fail++; $display("FAIL reset_err: err_count=%0d required 0", err_count);
    end
    n_tests++; if (step_idx !== '0) begin
      n_fail++; $display("FAIL reset_idx: step_idx=%0d required 0", step_idx);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Full-run check against the model, including strobe timing and bit order.
  task automatic test_pattern(input string name, input logic [L-1:0] pat, input int fm,
                              input int restart_cyc, input logic [L-1:0] alt_pat);
    int d_cyc, e_err, e_idx, e_done, e_steps, o_err, o_idx, en_n;
    logic o_pass, e_pass, b1;
    model(pat, fm, e_done, e_pass, e_err, e_idx, e_steps);
    do_run(pat, fm, restart_cyc, alt_pat, d_cyc, o_pass, o_err, o_idx, en_n, b1);
    n_tests++; if (b1 !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_early: busy=%b required 1", name, b1);
    end
    n_tests++; if (d_cyc != e_done) begin
      n_fail++; $display("FAIL %s done_cycle: got %0d required %0d", name, d_cyc, e_done);
    end
    n_tests++; if (o_pass !== e_pass) begin
      n_fail++; $display("FAIL %s pass: got %b required %b", name, o_pass, e_pass);
    end
    n_tests++; if (o_err != e_err) begin
      n_fail++; $display("FAIL %s err_count: got %0d required %0d", name, o_err, e_err);
    end
    n_tests++; if (o_idx != e_idx) begin
      n_fail++; $display("FAIL %s step_idx: got %0d required %0d", name, o_idx, e_idx);
    end
    n_tests++; if (en_n != e_steps) begin
      n_fail++; $display("FAIL %s strobe_count: got %0d required %0d", name, en_n, e_steps);
    end
    for (int j = 0; j < e_steps && j < en_n; j++) begin
      n_tests++; if (en_cyc[j] != j * STEP + S || en_bit[j] !== pat[j]) begin
        n_fail++; $display("FAIL %s strobe%0d: cycle %0d bit %b required cycle %0d bit %b",
                           name, j, en_cyc[j], en_bit[j], j * STEP + S, pat[j]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int done_seen = 0;
    int busy_seen = 0;
    fault_mode = 0;
    @(negedge clk);
    pattern = 8'hFF;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    repeat (23) @(negedge clk);    // now inside step 3
    n_tests++; if (busy !== 1'b1 || d_out !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: busy=%b d_out=%b required 1 1", busy, d_out);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if ({d_out, dut_en, busy, done, pass} !== 5'b0 || err_count !== '0 || step_idx !== '0) begin
      n_fail++; $display("FAIL rst_mid_values: {d,en,busy,done,pass}=%b err=%0d idx=%0d required 00000 0 0",
                         {d_out, dut_en, busy, done, pass}, err_count, step_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    n_tests++; if (done_seen != 0 || busy_seen != 0) begin
      n_fail++; $display("FAIL rst_mid_quiet: done pulses %0d busy cycles %0d required 0 0",
                         done_seen, busy_seen);
    end
    test_pattern("rst_mid_restart", 8'b1011_0010, 0, 0, '0);
  endtask

  task automatic test_start_in_done();
    int busy_seen = 0;
    test_pattern("start_in_done", 8'h3C, 0, STEP * L + 1, 8'hFF);
    repeat (5) begin
      @(posedge clk); #1;
      if (busy || dut_en) busy_seen++;
    end
    n_tests++; if (busy_seen != 0) begin
      n_fail++; $display("FAIL start_in_done_ignored: active cycles %0d required 0", busy_seen);
    end
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 6; i++) begin
      logic [L-1:0] p;
      int fm;
      p  = L'($urandom);
      fm = int'($urandom_range(0, 2));
      test_pattern($sformatf("random%0d_m%0d", i, fm), p, fm, 0, '0);
    end
  endtask

  initial begin
    test_reset();
    test_pattern("ideal", 8'b1011_0010, 0, 0, '0);
    test_pattern("stuck0", 8'hA5, 1, 0, '0);
    test_pattern("broken_notq", 8'h0F, 2, 0, '0);
    test_pattern("stuck0_bit2", 8'b0000_0100, 1, 0, '0);
    test_pattern("start_while_busy", 8'hA5, 1, 20, 8'hFF);
    test_reset_mid_run();
    test_start_in_done();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
